de10_lite_mem_responder: RTL and testbench

Memory-side responder for the multicycle processor's data/instruction port on DE10-Lite. It accepts word-addressed read/write requests over a req/ack handshake and services them from an internal RAM or a small MMIO window (LED register, switch inputs). Wait states are configurable. It is the target end of the address/write-enable interface the control FSM drives.

---
 rtl/de10_lite_mem_responder.sv | 159 +++++++++++++++
 tb/tb_de10_lite_mem_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de10_lite_mem_responder.sv
// Word-addressed req/ack memory target: internal RAM plus LED/switch MMIO with configurable wait states.
// Define MEM_ACCESS_COUNT_EN to map a completed-access counter at 0xF2 (otherwise 0xF2 is an error address).
module de10_lite_mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int RAM_DEPTH   = 128,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    input  logic [DATA_W-1:0] sw_in,
    output logic [DATA_W-1:0] led_out
);

    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(8'hF0);
    localparam logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(8'hF1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, next_state;

    logic [3:0]        wait_cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] sw_sync1, sw_sync2, sw_snap;
    logic [DATA_W-1:0] mem [RAM_DEPTH];

    // In IDLE the live request is decoded so a zero-wait access can capture rdata on acceptance.
    logic [ADDR_W-1:0] dec_addr;
    logic              dec_we;
    logic [DATA_W-1:0] sw_view;
    logic [RAM_AW-1:0] ram_idx;
    logic              is_ram, is_led, is_sw, is_cnt, dec_err;
    logic [DATA_W-1:0] read_val;

    assign dec_addr = (state == S_IDLE) ? addr : addr_q;
    assign dec_we   = (state == S_IDLE) ? we : we_q;
    assign sw_view  = (state == S_IDLE) ? sw_sync2 : sw_snap;
    assign ram_idx  = dec_addr[RAM_AW-1:0];

    assign is_ram = 32'(dec_addr) < 32'(RAM_DEPTH);
    assign is_led = (dec_addr == LED_ADDR);
    assign is_sw  = (dec_addr == SW_ADDR);

`ifdef MEM_ACCESS_COUNT_EN
    localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(8'hF2);
    logic [DATA_W-1:0] acc_cnt;
    assign is_cnt = (dec_addr == CNT_ADDR);
`else
    assign is_cnt = 1'b0;
`endif

    assign dec_err = !(is_ram || is_led || is_sw || is_cnt);

    always_comb begin
        read_val = '0;
        if (is_ram)
            read_val = mem[ram_idx];
        if (is_led)
            read_val = led_out;
        if (is_sw)
            read_val = sw_view;
`ifdef MEM_ACCESS_COUNT_EN
        if (is_cnt)
            read_val = acc_cnt;
`endif
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (req) next_state = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (wait_cnt == 4'd0) next_state = S_RESP;
            S_RESP: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign ack  = (state == S_RESP);
    assign busy = (state != S_IDLE);
    assign err  = ack && dec_err;

    // The switch value is frozen at acceptance, so a read never sees a switch change made in its own request cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sw_sync1 <= '0;
            sw_sync2 <= '0;
            sw_snap  <= '0;
            rdata    <= '0;
            led_out  <= '0;
        end else begin
            state    <= next_state;
            sw_sync1 <= sw_in;
            sw_sync2 <= sw_sync1;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        sw_snap  <= sw_sync2;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt != 4'd0)
                        wait_cnt <= wait_cnt - 4'd1;
                end
                S_RESP: begin
                    if (we_q && is_led)
                        led_out <= wdata_q;
                end
                default: ;
            endcase
            if (next_state == S_RESP && !dec_we)
                rdata <= read_val;
        end
    end

    // RAM contents survive reset; a reset on the closing edge still blocks the commit.
    always_ff @(posedge clk) begin
        if (reset && state == S_RESP && we_q && is_ram)
            mem[ram_idx] <= wdata_q;
    end

`ifdef MEM_ACCESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset)
            acc_cnt <= '0;
        else if (state == S_RESP && !dec_err) begin
            if (we_q && is_cnt)
                acc_cnt <= '0;
            else
                acc_cnt <= acc_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_de10_lite_mem_responder.sv
// Scoreboard bench for de10_lite_mem_responder with WAIT_STATES=2; honours MEM_ACCESS_COUNT_EN.
module tb_de10_lite_mem_responder;

    localparam int WS = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req, we;
    logic [7:0] addr, wdata, sw_in;
    logic       ack, err, busy;
    logic [7:0] rdata, led_out;

    de10_lite_mem_responder #(
        .DATA_W(8), .ADDR_W(8), .RAM_DEPTH(128), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .err(err), .busy(busy), .sw_in(sw_in), .led_out(led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       chk_rdata;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] obs_rdata;
    logic       obs_err;
    logic       obs_timeout;
    int         obs_lat;

    // Drives one request (with a simultaneous switch value) and records the response; no checking here.
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] sw);
        int n;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d; sw_in = sw;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 20);
        obs_timeout = !ack;
        obs_lat     = n;
        obs_rdata   = rdata;
        obs_err     = err;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sw_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 5;
        if (ack !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_ack: got %b expected 0", ack); end
        if (err !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        if (busy !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (rdata !== 8'h00)  begin n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 00", rdata); end
        if (led_out !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_led: got %h expected 00", led_out); end
        reset = 1'b1;
    endtask

    task automatic test_ram();
        logic [7:0] addrs [4];
        logic [7:0] vals  [4];
        addrs = '{8'h10, 8'h00, 8'h7F, 8'h33};
        vals  = '{8'h5A, 8'hA5, 8'h3E, 8'h91};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{rdata: 8'h00, err: 1'b0, chk_rdata: 1'b0});
            issue(1'b1, addrs[i], vals[i], sw_in);
            e = sb.pop_front();
            n_checks += 2;
            if (obs_timeout || obs_err !== e.err) begin
                n_fail++;
                $display("[TB] FAIL ram_write %h: got err=%b timeout=%b expected err=%b", addrs[i], obs_err, obs_timeout, e.err);
            end
            if (obs_lat !== WS + 1) begin
                n_fail++;
                $display("[TB] FAIL ram_write_latency: got %0d expected %0d", obs_lat, WS + 1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{rdata: vals[i], err: 1'b0, chk_rdata: 1'b1});
            issue(1'b0, addrs[i], 8'hEE, sw_in);
            e = sb.pop_front();
            n_checks += 2;
            if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata) begin
                n_fail++;
                $display("[TB] FAIL ram_read %h: got rdata=%h err=%b timeout=%b expected rdata=%h err=%b",
                         addrs[i], obs_rdata, obs_err, obs_timeout, e.rdata, e.err);
            end
            if (obs_lat !== WS + 1) begin
                n_fail++;
                $display("[TB] FAIL ram_read_latency: got %0d expected %0d", obs_lat, WS + 1);
            end
        end
    endtask

    task automatic test_led();
        sb.push_back('{rdata: 8'h00, err: 1'b0, chk_rdata: 1'b0});
        issue(1'b1, 8'hF0, 8'hC3, sw_in);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err) begin
            n_fail++;
            $display("[TB] FAIL led_write: got err=%b timeout=%b expected err=%b", obs_err, obs_timeout, e.err);
        end
        n_checks++;
        if (led_out !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL led_before_commit: got %h expected 00", led_out);
        end
        @(posedge clk); #1;
        n_checks++;
        if (led_out !== 8'hC3) begin
            n_fail++;
            $display("[TB] FAIL led_after_commit: got %h expected c3", led_out);
        end
        sb.push_back('{rdata: 8'hC3, err: 1'b0, chk_rdata: 1'b1});
        issue(1'b0, 8'hF0, 8'h00, sw_in);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL led_read: got rdata=%h err=%b expected rdata=%h err=%b", obs_rdata, obs_err, e.rdata, e.err);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n_checks++;
        if (led_out !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL led_after_reset: got %h expected 00", led_out);
        end
        sb.push_back('{rdata: 8'h5A, err: 1'b0, chk_rdata: 1'b1});
        issue(1'b0, 8'h10, 8'h00, sw_in);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL ram_survives_reset: got rdata=%h err=%b expected rdata=%h err=%b", obs_rdata, obs_err, e.rdata, e.err);
        end
    endtask

    task automatic test_switch();
        @(posedge clk); #1;
        sw_in = 8'h81;
        repeat (4) @(posedge clk);
        sb.push_back('{rdata: 8'h81, err: 1'b0, chk_rdata: 1'b1});
        issue(1'b0, 8'hF1, 8'h00, 8'h81);
        // Switch changes in the very cycle the read is presented: old value expected.
        sb.push_back('{rdata: 8'h81, err: 1'b0, chk_rdata: 1'b1});
        repeat (4) @(posedge clk);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL sw_read_settled: got rdata=%h err=%b expected rdata=%h err=%b", obs_rdata, obs_err, e.rdata, e.err);
        end
        issue(1'b0, 8'hF1, 8'h00, 8'h3C);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL sw_read_same_cycle: got rdata=%h err=%b expected rdata=%h err=%b", obs_rdata, obs_err, e.rdata, e.err);
        end
        sb.push_back('{rdata: 8'h00, err: 1'b0, chk_rdata: 1'b0});
        issue(1'b1, 8'hF1, 8'h55, sw_in);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err) begin
            n_fail++;
            $display("[TB] FAIL sw_write_ignored: got err=%b timeout=%b expected err=%b", obs_err, obs_timeout, e.err);
        end
        sb.push_back('{rdata: 8'h3C, err: 1'b0, chk_rdata: 1'b1});
        issue(1'b0, 8'hF1, 8'h00, sw_in);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL sw_read_new: got rdata=%h err=%b expected rdata=%h err=%b", obs_rdata, obs_err, e.rdata, e.err);
        end
    endtask

    task automatic test_error();
        logic [7:0] bad [4];
`ifdef MEM_ACCESS_COUNT_EN
        bad = '{8'h90, 8'h80, 8'hF3, 8'hEF};
`else
        bad = '{8'h90, 8'h80, 8'hF2, 8'hEF};
`endif
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{rdata: 8'h00, err: 1'b1, chk_rdata: 1'b1});
            issue(1'b0, bad[i], 8'h00, sw_in);
            e = sb.pop_front();
            n_checks++;
            if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata) begin
                n_fail++;
                $display("[TB] FAIL err_read %h: got rdata=%h err=%b expected rdata=%h err=%b", bad[i], obs_rdata, obs_err, e.rdata, e.err);
            end
        end
        sb.push_back('{rdata: 8'h5A, err: 1'b0, chk_rdata: 1'b1});
        issue(1'b0, 8'h10, 8'h00, sw_in);
        void'(sb.pop_front());
        // A write response, even an erroring one, must leave rdata at the last read value.
        sb.push_back('{rdata: 8'h5A, err: 1'b1, chk_rdata: 1'b1});
        issue(1'b1, 8'hFF, 8'h99, sw_in);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL err_write: got rdata=%h err=%b expected rdata=%h err=%b", obs_rdata, obs_err, e.rdata, e.err);
        end
        sb.push_back('{rdata: 8'h00, err: 1'b1, chk_rdata: 1'b0});
        issue(1'b1, 8'h90, 8'h99, sw_in);
        void'(sb.pop_front());
        sb.push_back('{rdata: 8'h5A, err: 1'b0, chk_rdata: 1'b1});
        issue(1'b0, 8'h10, 8'h00, sw_in);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata || led_out !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL err_no_side_effect: got rdata=%h err=%b led=%h expected rdata=%h err=%b led=00",
                     obs_rdata, obs_err, led_out, e.rdata, e.err);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        sb.push_back('{rdata: 8'h00, err: 1'b0, chk_rdata: 1'b0});
        issue(1'b1, 8'h20, 8'h11, sw_in);
        void'(sb.pop_front());
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 8'h77;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_busy: got %b expected 1", busy);
        end
        reset = 1'b0; req = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            if (ack) acks++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (acks !== 0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_ack: got %0d acks expected 0", acks);
        end
        sb.push_back('{rdata: 8'h11, err: 1'b0, chk_rdata: 1'b1});
        issue(1'b0, 8'h20, 8'h00, sw_in);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_no_commit: got rdata=%h err=%b expected rdata=%h err=%b", obs_rdata, obs_err, e.rdata, e.err);
        end
    endtask

    task automatic test_counter();
`ifdef MEM_ACCESS_COUNT_EN
        issue(1'b1, 8'hF2, 8'hAB, sw_in);
        issue(1'b1, 8'h40, 8'h01, sw_in);
        issue(1'b0, 8'h40, 8'h00, sw_in);
        issue(1'b0, 8'hF0, 8'h00, sw_in);
        issue(1'b0, 8'hA0, 8'h00, sw_in);
        sb.push_back('{rdata: 8'h03, err: 1'b0, chk_rdata: 1'b1});
        issue(1'b0, 8'hF2, 8'h00, sw_in);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL cnt_value: got rdata=%h err=%b expected rdata=%h err=%b", obs_rdata, obs_err, e.rdata, e.err);
        end
        issue(1'b1, 8'hF2, 8'h12, sw_in);
        sb.push_back('{rdata: 8'h00, err: 1'b0, chk_rdata: 1'b1});
        issue(1'b0, 8'hF2, 8'h00, sw_in);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL cnt_clear: got rdata=%h err=%b expected rdata=%h err=%b", obs_rdata, obs_err, e.rdata, e.err);
        end
`else
        sb.push_back('{rdata: 8'h00, err: 1'b1, chk_rdata: 1'b1});
        issue(1'b0, 8'hF2, 8'h00, sw_in);
        e = sb.pop_front();
        n_checks++;
        if (obs_timeout || obs_err !== e.err || obs_rdata !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL cnt_absent: got rdata=%h err=%b expected rdata=%h err=%b", obs_rdata, obs_err, e.rdata, e.err);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 8'h10;
        for (int k = 0; k < 3; k++)
            sb.push_back('{rdata: 8'h5A, err: 1'b0, chk_rdata: 1'b1});
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_ack = ((k % (WS + 2)) == (WS + 1));
            n_checks++;
            if (ack !== exp_ack) begin
                n_fail++;
                $display("[TB] FAIL b2b_ack cycle %0d: got %b expected %b", k, ack, exp_ack);
            end
            if (ack === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (err !== e.err || rdata !== e.rdata) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_data: got rdata=%h err=%b expected rdata=%h err=%b", rdata, err, e.rdata, e.err);
                end
            end
        end
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        $display("[TB] starting de10_lite_mem_responder bench, WAIT_STATES=%0d", WS);
        test_reset();
        test_ram();
        test_led();
        test_switch();
        test_error();
        test_reset_mid();
        test_counter();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
